cmd_comm: RTL and testbench

//  Host-side UART link feeding the digital core's command interface.
//  - Receives 8N1 bytes on RX and assembles three of them into a 24-bit command; raises cmd_rdy.
//  - Transmits the core's response byte on TX when send_resp is pulsed; pulses resp_sent when done.
//  - Sits between the board UART pins and the core; RX and TX paths are fully independent (full duplex).

---
 rtl/cmd_comm.sv | 158 +++++++++++++++
 tb/tb_cmd_comm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_comm.sv
// Host UART link: 8N1 RX assembles 3-byte commands, TX sends a 1-byte response.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module cmd_comm #(
  parameter int BAUD_DIV     = 347,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] ONE  = BW'(1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic {TX_IDLE, TX_XMIT} tx_st_t;

  rx_st_t        r_rx_st;
  logic [1:0]    r_rx_sync;
  logic [BW-1:0] r_rx_bcnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic [23:0]   r_cmd;
  logic          r_cmd_rdy;
  logic [1:0]    r_byte_cnt;
  tx_st_t        r_tx_st;
  logic [9:0]    r_tx_shift;
  logic [BW-1:0] r_tx_bcnt;
  logic [3:0]    r_tx_bit;
  logic          r_resp_sent;

  logic w_rx, w_rx_end, w_rx_done, w_ferr, w_timeout;

  assign w_rx      = r_rx_sync[1];
  assign w_rx_end  = (r_rx_bcnt == LAST);
  assign w_rx_done = (r_rx_st == RX_STOP) && w_rx_end &&  w_rx;
  assign w_ferr    = (r_rx_st == RX_STOP) && w_rx_end && !w_rx;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rx_sync <= 2'b11;
    else        r_rx_sync <= {r_rx_sync[0], RX};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_st    <= RX_IDLE;
      r_rx_bcnt  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      case (r_rx_st)
        RX_IDLE: if (!w_rx) begin
          r_rx_st   <= RX_START;
          r_rx_bcnt <= '0;
        end
        RX_START: if (r_rx_bcnt == HALF) begin
          r_rx_bcnt <= '0;
          r_rx_bit  <= '0;
          r_rx_st   <= w_rx ? RX_IDLE : RX_DATA;
        end else r_rx_bcnt <= r_rx_bcnt + ONE;
        RX_DATA: if (w_rx_end) begin
          r_rx_bcnt  <= '0;
          r_rx_shift <= {w_rx, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) r_rx_st <= RX_STOP;
        end else r_rx_bcnt <= r_rx_bcnt + ONE;
        RX_STOP: if (w_rx_end) begin
          r_rx_bcnt <= '0;
          r_rx_st   <= RX_IDLE;
        end else r_rx_bcnt <= r_rx_bcnt + ONE;
        default: r_rx_st <= RX_IDLE;
      endcase
    end
  end

`ifdef CMD_TIMEOUT_EN
  localparam int TO_CLKS = TIMEOUT_BITS * BAUD_DIV;
  localparam int TW      = $clog2(TO_CLKS + 1);
  logic [TW-1:0] r_to_cnt;

  assign w_timeout = (r_to_cnt == TW'(TO_CLKS));

  // Runs only between bytes of a partial command; held while a byte is arriving.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                r_to_cnt <= '0;
    else if (w_rx_done || r_byte_cnt == 2'd0)  r_to_cnt <= '0;
    else if (r_rx_st == RX_IDLE && !w_timeout) r_to_cnt <= r_to_cnt + TW'(1);
`else
  // No inter-byte timeout; a partial command waits indefinitely.
  assign w_timeout = 1'b0 && (TIMEOUT_BITS > 0);
`endif

  // Bytes arriving while cmd_rdy is set are dropped so cmd stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd      <= '0;
      r_cmd_rdy  <= 1'b0;
      r_byte_cnt <= '0;
    end else begin
      if (clr_cmd_rdy) r_cmd_rdy <= 1'b0;
      if (w_ferr || w_timeout) begin
        r_byte_cnt <= '0;
      end else if (w_rx_done && !r_cmd_rdy) begin
        case (r_byte_cnt)
          2'd0:    r_cmd[23:16] <= r_rx_shift;
          2'd1:    r_cmd[15:8]  <= r_rx_shift;
          default: r_cmd[7:0]   <= r_rx_shift;
        endcase
        if (r_byte_cnt == 2'd2) begin
          r_byte_cnt <= '0;
          r_cmd_rdy  <= 1'b1;
        end else r_byte_cnt <= r_byte_cnt + 2'd1;
      end
    end
  end

  // TX is the LSB of an all-ones-filled shift register, so idle/reset is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_st     <= TX_IDLE;
      r_tx_shift  <= '1;
      r_tx_bcnt   <= '0;
      r_tx_bit    <= '0;
      r_resp_sent <= 1'b0;
    end else begin
      r_resp_sent <= 1'b0;
      case (r_tx_st)
        TX_IDLE: if (send_resp) begin
          r_tx_shift <= {1'b1, resp_data, 1'b0};
          r_tx_bcnt  <= '0;
          r_tx_bit   <= '0;
          r_tx_st    <= TX_XMIT;
        end
        TX_XMIT: if (r_tx_bcnt == LAST) begin
          r_tx_bcnt  <= '0;
          r_tx_shift <= {1'b1, r_tx_shift[9:1]};
          if (r_tx_bit == 4'd9) begin
            r_tx_st     <= TX_IDLE;
            r_resp_sent <= 1'b1;
          end else r_tx_bit <= r_tx_bit + 4'd1;
        end else r_tx_bcnt <= r_tx_bcnt + ONE;
        default: r_tx_st <= TX_IDLE;
      endcase
    end
  end

  assign TX        = r_tx_shift[0];
  assign cmd       = r_cmd;
  assign cmd_rdy   = r_cmd_rdy;
  assign resp_sent = r_resp_sent;
endmodule

// File: tb/tb_cmd_comm.sv
// Scoreboard bench for cmd_comm at BAUD_DIV=16: queued expected commands and
// response bytes are checked by independent cmd and TX monitors.
module tb_cmd_comm;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp_data = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_frames = 0;
  bit tx_mon_en = 1'b1;
  logic [23:0] exp_cmd[$];
  logic [7:0]  exp_tx[$];

  cmd_comm #(.BAUD_DIV(BD), .TIMEOUT_BITS(40)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp_data(resp_data), .send_resp(send_resp),
    .resp_sent(resp_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk) RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    if (stop_ok) begin
      RX = 1'b1;
      repeat (BD) @(negedge clk);
    end else begin
      // Hold a break long enough that any re-triggered frame also fails framing.
      RX = 1'b0;
      repeat (20 * BD) @(negedge clk);
      RX = 1'b1;
      repeat (2 * BD) @(negedge clk);
    end
  endtask

  task automatic send_cmd(input logic [23:0] c);
    send_byte(c[23:16], 1'b1);
    send_byte(c[15:8], 1'b1);
    send_byte(c[7:0], 1'b1);
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (cmd_rdy !== 1'b1 && n < 40 * BD) begin
      @(negedge clk);
      n++;
    end
    if (cmd_rdy !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_cmd_rdy timeout actual=0 expected=1");
    end
  endtask

  task automatic clr_rdy();
    @(negedge clk) clr_cmd_rdy = 1'b1;
    @(negedge clk) clr_cmd_rdy = 1'b0;
    chk("cmd_rdy_after_clr", {31'd0, cmd_rdy}, 32'd0);
  endtask

  task automatic pulse_send(input logic [7:0] d);
    resp_data = d;
    send_resp = 1'b1;
    @(negedge clk) send_resp = 1'b0;
  endtask

  // Command monitor: every rising cmd_rdy consumes one expected command.
  initial begin
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_rdy === 1'b1 && !prev) begin
        if (exp_cmd.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_cmd actual=%h expected=none", cmd);
        end else chk("cmd_value", {8'd0, cmd}, {8'd0, exp_cmd.pop_front()});
      end
      prev = (cmd_rdy === 1'b1);
    end
  end

  // TX monitor: decodes each frame at bit centres and times resp_sent.
  initial begin
    int t0;
    logic [9:0] bits;
    forever begin
      if (tx_mon_en && rst_n === 1'b1 && TX === 1'b0) begin
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
          while (cyc < t0 + BD / 2 + BD * i) @(negedge clk);
          bits[i] = TX;
        end
        chk("tx_start_bit", {31'd0, bits[0]}, 32'd0);
        chk("tx_stop_bit", {31'd0, bits[9]}, 32'd1);
        if (exp_tx.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_tx_frame actual=%h expected=none", bits[8:1]);
        end else chk("tx_data", {24'd0, bits[8:1]}, {24'd0, exp_tx.pop_front()});
        while (resp_sent !== 1'b1 && cyc < t0 + 12 * BD) @(negedge clk);
        chk("resp_sent_latency", cyc - t0, 10 * BD);
        @(negedge clk);
        chk("resp_sent_pulse_width", {31'd0, resp_sent}, 32'd0);
        n_frames++;
      end else @(negedge clk);
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_TX", {31'd0, TX}, 32'd1);
    chk("rst_cmd", {8'd0, cmd}, 32'd0);
    chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("rst_resp_sent", {31'd0, resp_sent}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic command, held until cleared
    exp_cmd.push_back(24'h012345);
    send_cmd(24'h012345);
    wait_rdy();
    repeat (30) @(negedge clk);
    chk("cmd_rdy_held", {31'd0, cmd_rdy}, 32'd1);
    chk("cmd_held", {8'd0, cmd}, 32'h00012345);
    clr_rdy();

    // Response; mid-frame request ignored; re-accept in the resp_sent cycle
    exp_tx.push_back(8'hA5);
    @(negedge clk) pulse_send(8'hA5);
    repeat (50) @(negedge clk);
    pulse_send(8'h3C);
    n = 0;
    while (resp_sent !== 1'b1 && n < 12 * BD) begin @(negedge clk); n++; end
    chk("resp_sent_seen", {31'd0, resp_sent}, 32'd1);
    exp_tx.push_back(8'h5A);
    pulse_send(8'h5A);
    repeat (12 * BD) @(negedge clk);

    // Glitch, then framing error drops a partial command
    @(negedge clk) RX = 1'b0;
    repeat (5) @(negedge clk);
    RX = 1'b1;
    repeat (2 * BD) @(negedge clk);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    exp_cmd.push_back(24'hAABBCC);
    send_cmd(24'hAABBCC);
    wait_rdy();

    // Byte while cmd_rdy is dropped
    send_byte(8'h77, 1'b1);
    repeat (4) @(negedge clk);
    chk("cmd_stable_while_rdy", {8'd0, cmd}, 32'h00AABBCC);
    chk("cmd_rdy_stays", {31'd0, cmd_rdy}, 32'd1);
    clr_rdy();
    exp_cmd.push_back(24'h102030);
    send_cmd(24'h102030);
    wait_rdy();
    clr_rdy();

    // Inter-byte idle longer than the timeout window
`ifdef CMD_TIMEOUT_EN
    exp_cmd.push_back(24'h010203);
`else
    exp_cmd.push_back(24'h990102);
`endif
    send_byte(8'h99, 1'b1);
    repeat (700) @(negedge clk);
    send_cmd(24'h010203);
    wait_rdy();
    clr_rdy();

    // Reset mid-TX and mid-RX with a partial command pending
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    tx_mon_en = 1'b0;
    pulse_send(8'h00);
    RX = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_TX", {31'd0, TX}, 32'd1);
    chk("midrst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("midrst_cmd", {8'd0, cmd}, 32'd0);
    RX = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    tx_mon_en = 1'b1;
    exp_cmd.push_back(24'h112233);
    send_cmd(24'h112233);
    wait_rdy();
    clr_rdy();

    repeat (20) @(negedge clk);
    chk("tx_frames", n_frames, 2);
    chk("cmd_queue_drained", exp_cmd.size(), 0);
    chk("tx_queue_drained", exp_tx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
